// File: rtl/dds_sweep_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dds_sweep_ctrl
//  Description : Steps a DDS through a programmable frequency sweep, holding
//                each step for a number of output periods and measuring them.
//  Revision    : 1.0 - initial release
// ============================================================================
module dds_sweep_ctrl #(
    parameter int CNT_W   = 16,
    parameter int DWELL_W = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic               STOP,
    input  logic [7:0]         start_step,
    input  logic [7:0]         stop_step,
    input  logic [7:0]         inc_step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               zero_address,
    output logic               SET,
    output logic [7:0]         step_out,
    output logic [CNT_W-1:0]   period_len,
    output logic               period_valid,
    output logic               busy,
    output logic               done,
    output logic               error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ALIGN  = 3'd2,
        S_DWELL  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_za_prev;
    logic                 r_rdy;
    logic [CNT_W-1:0]     r_cnt;
    logic [DWELL_W-1:0]   r_per_cnt;
    logic [7:0]           r_stop_step;
    logic [7:0]           r_inc_step;
    logic [DWELL_W-1:0]   r_dwell;

    logic                 w_za_evt;
    logic                 w_cnt_max;
    logic [DWELL_W-1:0]   w_dwell_eff;
    logic [DWELL_W-1:0]   w_per_next;
    logic [8:0]           w_sum;
    logic                 w_last;
    logic                 w_cfg_ok;

    assign w_za_evt    = zero_address & ~r_za_prev;
    assign w_cnt_max   = &r_cnt;
    assign w_dwell_eff = (r_dwell == '0) ? DWELL_W'(1) : r_dwell;
    assign w_per_next  = r_per_cnt + DWELL_W'(1);
    assign w_sum       = {1'b0, step_out} + {1'b0, r_inc_step};
    // A carry out of bit 7 also ends the sweep, so a wrapped step is never loaded
    assign w_last      = w_sum[8] | (w_sum[7:0] > r_stop_step);
    assign w_cfg_ok    = (start_step != 8'd0) && (inc_step != 8'd0);
    assign busy        = (r_state != S_IDLE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= S_IDLE;
            r_za_prev    <= 1'b0;
            r_rdy        <= 1'b0;
            r_cnt        <= '0;
            r_per_cnt    <= '0;
            r_stop_step  <= 8'd0;
            r_inc_step   <= 8'd0;
            r_dwell      <= '0;
            step_out     <= 8'h01;
            period_len   <= '0;
            SET          <= 1'b0;
            period_valid <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            SET          <= 1'b0;
            period_valid <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            r_za_prev    <= zero_address;
            r_rdy        <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (START && r_rdy) begin
                        if (w_cfg_ok) begin
                            step_out    <= start_step;
                            r_stop_step <= stop_step;
                            r_inc_step  <= inc_step;
                            r_dwell     <= dwell;
                            r_state     <= S_LOAD;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    if (STOP) begin
                        r_state <= S_IDLE;
                    end else begin
                        SET     <= 1'b1;
                        r_cnt   <= CNT_W'(1);
                        r_state <= S_ALIGN;
                    end
                end

                S_ALIGN: begin
                    if (STOP) begin
                        r_state <= S_IDLE;
                    end else if (w_za_evt) begin
                        r_cnt     <= CNT_W'(1);
                        r_per_cnt <= '0;
                        r_state   <= S_DWELL;
                    end else if (w_cnt_max) begin
                        error   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_DWELL: begin
                    if (STOP) begin
                        r_state <= S_IDLE;
                    end else if (w_za_evt) begin
                        period_len   <= r_cnt;
                        period_valid <= 1'b1;
                        r_cnt        <= CNT_W'(1);
                        if (w_per_next == w_dwell_eff) begin
                            r_per_cnt <= '0;
                            if (w_last) begin
                                r_state <= S_FINISH;
                            end else begin
                                step_out <= w_sum[7:0];
                                r_state  <= S_LOAD;
                            end
                        end else begin
                            r_per_cnt <= w_per_next;
                        end
                    end else if (w_cnt_max) begin
                        error   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_FINISH: begin
                    if (!STOP) begin
                        done <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
